// File: rtl/bcd_sevenseg_scan.sv
// bcd_sevenseg_scan
// Captures a packed 4-digit BCD word and scans it onto a 4-digit common-anode
// seven-segment display. Each digit owns a slot of REFRESH_DIV cycles. The
// first GUARD cycles of a slot keep every anode off so the previous digit's
// segments never bleed into the next one. Leading zeros can be blanked, each
// digit has its own decimal point, and non-BCD nibbles are shown as a dash.
// All pins are registered, one cycle behind the scan state.

module bcd_sevenseg_scan #(
  parameter int REFRESH_DIV = 100000,  // cycles per digit slot, 4..2^20
  parameter int GUARD       = 16       // dark cycles per slot, 1..REFRESH_DIV-1
) (
  input  logic        CLK,
  input  logic        RST,       // asynchronous, active-low
  input  logic        LOAD,
  input  logic [15:0] BCDIN,
  input  logic [3:0]  DPIN,
  input  logic        BLANK_EN,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  typedef enum logic {
    GUARD_S = 1'b0,
    SHOW_S  = 1'b1
  } state_e;

  // Shadow of the displayed value
  logic [15:0] bcd_q;
  logic [3:0]  dpm_q;

  // Scan timing
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  state_e           state_q, state_d;

  // Registered pins
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;

  // Per-digit decode helpers
  logic [3:0] nib;
  logic       zero3, zero2, zero1;
  logic       blank_digit;

  // Active-low glyph for one nibble; anything above 9 becomes a dash.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    unique case (n)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = SEG_DASH;
    endcase
    return g;
  endfunction

  // Capture a new value on LOAD, independent of where the scan is.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bcd_q <= 16'h0000;
      dpm_q <= 4'b0000;
    end else if (LOAD) begin
      bcd_q <= BCDIN;
      dpm_q <= DPIN;
    end
  end

  // Slot counter, digit index and guard/show state for the next cycle.
  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    state_d = state_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      idx_d   = idx_q + 2'd1;
      state_d = GUARD_S;
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == GUARD_C) begin
        state_d = SHOW_S;
      end
    end
  end

  // Scan timing registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      state_q <= GUARD_S;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      state_q <= state_d;
    end
  end

  // Select the current digit and decide whether it is a blanked leading zero.
  always_comb begin
    nib = 4'h0;
    unique case (idx_q)
      2'd0: nib = bcd_q[3:0];
      2'd1: nib = bcd_q[7:4];
      2'd2: nib = bcd_q[11:8];
      2'd3: nib = bcd_q[15:12];
      default: nib = 4'h0;
    endcase

    // Blanking runs from the thousands digit down and stops at the first
    // nibble that is not zero; a non-BCD nibble is not zero.
    zero3 = (bcd_q[15:12] == 4'h0);
    zero2 = zero3 && (bcd_q[11:8] == 4'h0);
    zero1 = zero2 && (bcd_q[7:4] == 4'h0);

    blank_digit = 1'b0;
    if (BLANK_EN) begin
      unique case (idx_q)
        2'd3:    blank_digit = zero3;
        2'd2:    blank_digit = zero2;
        2'd1:    blank_digit = zero1;
        default: blank_digit = 1'b0;
      endcase
    end
  end

  // Next pin values: dark during the guard, otherwise the selected digit.
  always_comb begin
    an_d  = 4'b1111;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state_q == SHOW_S) begin
      an_d        = 4'b1111;
      an_d[idx_q] = 1'b0;
      seg_d       = blank_digit ? SEG_OFF : glyph(nib);
      dp_d        = ~dpm_q[idx_q];
    end
  end

  // Output registers; reset forces the display dark without waiting for a clock.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      an_q  <= 4'b1111;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign AN  = an_q;
  assign SEG = seg_q;
  assign DP  = dp_q;

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// Testbench for bcd_sevenseg_scan with a short slot (8 cycles, 2 guard).
// A cycle model predicts {AN,SEG,DP} for each edge from elapsed time since
// reset; predictions are queued when the inputs are driven and compared on
// the following falling edge.

module tb_bcd_sevenseg_scan;

  localparam int DIV = 8;
  localparam int GRD = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        LOAD = 1'b0;
  logic [15:0] BCDIN = 16'h0000;
  logic [3:0]  DPIN = 4'b0000;
  logic        BLANK_EN = 1'b0;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP;

  bcd_sevenseg_scan #(
    .REFRESH_DIV (DIV),
    .GUARD       (GRD)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .LOAD     (LOAD),
    .BCDIN    (BCDIN),
    .DPIN     (DPIN),
    .BLANK_EN (BLANK_EN),
    .AN       (AN),
    .SEG      (SEG),
    .DP       (DP)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: cycles into the current slot, digit, captured value
  int          m_cnt = 0;
  int          m_idx = 0;
  logic [15:0] m_bcd = 16'h0000;
  logic [3:0]  m_dp  = 4'b0000;

  logic [11:0] exp_q[$];

  logic [6:0] glyph_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
  };

  task automatic check(input string tag, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: {AN,SEG,DP} got %b_%b_%b expected %b_%b_%b (t=%0t)",
               tag, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0], $time);
    end
  endtask

  // Expected pins for one digit, packed as {AN,SEG,DP}.
  function automatic logic [11:0] exp_out(input bit show, input int idx,
                                          input logic [15:0] b, input logic [3:0] d,
                                          input bit ben);
    logic [3:0] an;
    logic [6:0] seg;
    logic [3:0] nib;
    bit         blank;
    if (!show) return 12'hFFF;
    an  = ~(4'b0001 << idx);
    nib = b[idx*4 +: 4];
    blank = ben && (idx != 0);
    for (int j = idx; j < 4; j++) begin
      if (b[j*4 +: 4] != 4'h0) blank = 0;
    end
    seg = blank ? 7'b1111111 : glyph_tbl[nib];
    return {an, seg, ~d[idx]};
  endfunction

  // One clock: predict, clock, advance model, compare on the falling edge.
  task automatic cycle(input string tag);
    exp_q.push_back(exp_out(m_cnt >= GRD, m_idx, m_bcd, m_dp, BLANK_EN));
    @(posedge CLK);
    if (LOAD) begin
      m_bcd = BCDIN;
      m_dp  = DPIN;
    end
    if (m_cnt == DIV - 1) begin
      m_cnt = 0;
      m_idx = (m_idx + 1) % 4;
    end else begin
      m_cnt++;
    end
    @(negedge CLK);
    check(tag, {AN, SEG, DP}, exp_q.pop_front());
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic load(input string tag, input logic [15:0] b, input logic [3:0] d);
    BCDIN = b;
    DPIN  = d;
    LOAD  = 1'b1;
    cycle(tag);
    LOAD  = 1'b0;
  endtask

  // Advance until the model is at the given digit and slot position.
  task automatic seek(input int idx, input int pos);
    int budget;
    budget = 0;
    while (!(m_idx == idx && m_cnt == pos) && budget < 4 * DIV + 1) begin
      cycle("seek");
      budget++;
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_idx = 0;
    m_bcd = 16'h0000;
    m_dp  = 4'b0000;
    exp_q.delete();
  endtask

  initial begin
    // Power-on reset with the clock running
    #2 RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("reset_dark", {AN, SEG, DP}, 12'hFFF);
    end
    RST = 1'b1;
    model_reset();

    // First slot and plain scan of 1234
    load("scan_1234", 16'h1234, 4'b0000);
    run("scan_1234", 8 * DIV);

    // Leading-zero blanking, then the same value unblanked
    BLANK_EN = 1'b1;
    load("blank_0070", 16'h0070, 4'b0000);
    run("blank_0070", 4 * DIV + 2);
    BLANK_EN = 1'b0;
    run("noblank_0070", 4 * DIV);

    // All zero: only the ones digit is lit
    BLANK_EN = 1'b1;
    load("blank_0000", 16'h0000, 4'b0000);
    run("blank_0000", 4 * DIV + 2);

    // Non-BCD nibble ends blanking and shows a dash
    load("dash_0a05", 16'h0A05, 4'b0000);
    run("dash_0a05", 4 * DIV + 2);

    // Decimal point on digit 2 only
    BLANK_EN = 1'b0;
    load("dp_9999", 16'h9999, 4'b0100);
    run("dp_9999", 4 * DIV + 2);

    // Toggle blanking in the middle of a show slot
    load("toggle_0005", 16'h0005, 4'b0000);
    seek(3, 4);
    BLANK_EN = 1'b1;
    run("toggle_blank", 3);
    BLANK_EN = 1'b0;
    run("toggle_blank", 3);

    // Capture on the wrap cycle
    seek(1, DIV - 1);
    load("wrap_load", 16'h4321, 4'b1000);
    run("wrap_load", 4 * DIV + 2);

    // Mid-slot load during digit 0 show
    seek(0, 4);
    load("mid_load", 16'h0008, 4'b0000);
    run("mid_load", 2);
    check("mid_load_lit", {AN, SEG, DP}, {4'b1110, 7'b0000000, 1'b1});

    // Asynchronous reset mid-slot, checked before the next rising edge
    #2 RST = 1'b0;
    #1 check("async_reset", {AN, SEG, DP}, 12'hFFF);
    @(negedge CLK);
    check("reset_hold", {AN, SEG, DP}, 12'hFFF);
    RST = 1'b1;
    model_reset();
    run("after_reset", 4 * DIV + 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/bcd_sevenseg_scan.md
Name: bcd_sevenseg_scan

Overview:
- Downstream consumer of the 4-digit packed BCD produced by the binary-to-BCD converter.
- Captures a BCD word on a load strobe and time-multiplexes it onto a 4-digit common-anode seven-segment display (Nexys-class board, 100 MHz CLK).
- Provides leading-zero blanking, per-digit decimal points, an anti-ghosting guard interval and a dash glyph for non-BCD nibbles.

Parameters:
- REFRESH_DIV, 100000, CLK cycles per digit slot (1 kHz per digit at 100 MHz); legal range 4..2^20.
- GUARD, 16, cycles at the start of each slot with all anodes off; must satisfy 1 <= GUARD < REFRESH_DIV.

Ports:
- CLK  input  1  system clock, 100 MHz.
- RST  input  1  asynchronous, active-low reset.
- LOAD  input  1  single-cycle strobe; captures BCDIN and DPIN.
- BCDIN  input  16  packed BCD: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
- DPIN  input  4  decimal point enables, bit i = digit i, 1 = lit.
- BLANK_EN  input  1  1 = leading-zero blanking on; sampled live every cycle.
- AN  output  4  anode enables, active-low, AN[0] = ones digit.
- SEG  output  7  cathodes, active-low, {g,f,e,d,c,b,a}.
- DP  output  1  decimal point cathode, active-low.

Behaviour:
- Reset (RST=0, asynchronous):
  - AN=4'b1111, SEG=7'b1111111, DP=1.
  - Shadow BCD=16'h0000, shadow DP=4'b0000.
  - Slot counter=0, digit index=0, state=GUARD_S.
- Shadow registers:
  - On a CLK edge with LOAD=1, shadow <= BCDIN/DPIN; otherwise they hold.
  - LOAD is accepted in any state; it does not restart the slot timing.
- Slot counter:
  - Counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1 it wraps to 0 and the digit index advances 0->1->2->3->0 (2-bit wrap).
- State machine (2 states):
  - GUARD_S: active while counter < GUARD; GUARD_S -> SHOW_S when the counter reaches GUARD.
  - SHOW_S: active while GUARD <= counter <= REFRESH_DIV-1; SHOW_S -> GUARD_S on the counter wrap.
- Outputs are registered, computed from the current state, index and shadow each cycle, so there is 1 cycle of latency from counter/index to pins.
  - GUARD_S: AN=1111, SEG=1111111, DP=1.
  - SHOW_S: AN = one-hot-low of index (index 2 -> 4'b1011); SEG = glyph of the selected nibble; DP = ~shadowDP[index].
- Glyphs (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - nibble 10..15 = dash 0111111
- Leading-zero blanking (BLANK_EN=1):
  - Digit 3 is blank if it is 0.
  - Digit 2 is blank if digits 3 and 2 are both 0.
  - Digit 1 is blank if digits 3, 2 and 1 are all 0.
  - Digit 0 is never blanked.
  - A blank digit drives SEG=1111111, but its AN is still asserted and DP still follows DPIN.
  - A non-BCD nibble counts as non-zero and terminates blanking.
- Latency:
  - LOAD sampled at edge k updates the shadow at edge k.
  - The new value appears on SEG at edge k+1 if that digit is in SHOW_S.
- Boundary conditions:
  - LOAD on the wrap cycle: the index advance and the capture both occur, with no interaction.
  - Reset mid-slot: outputs go off immediately (asynchronously); after release, scanning restarts at digit 0 in GUARD_S.
  - BLANK_EN toggled mid-slot: takes effect on the next registered output.

Test Plan:
- Reset and first slot (REFRESH_DIV=8, GUARD=2): hold RST=0, then release; LOAD BCDIN=16'h1234, DPIN=0.
  - -> AN=1111 through the guard cycles.
  - -> then AN=1110, SEG=0011001 ('4') for 6 cycles.
  - -> then digits 1,2,3 show '3','2','1' with AN=1101, 1011, 0111, and the sequence repeats.
- Leading-zero blanking: LOAD 16'h0070, BLANK_EN=1.
  - -> digits 3 and 2: SEG=1111111 while AN is asserted.
  - -> digit 1: SEG=1111000 ('7').
  - -> digit 0: SEG=1000000 ('0').
  - -> with BLANK_EN=0, digits 3 and 2 show '0'.
- Zero and invalid nibbles:
  - LOAD 16'h0000, BLANK_EN=1 -> only digit 0 lit ('0'); the other slots are blank.
  - LOAD 16'h0A05 -> digit 2 shows dash 0111111, digit 1 shows '0' (not blanked), digit 0 shows '5'.
- Decimal points: LOAD 16'h9999, DPIN=4'b0100.
  - -> DP=0 only during the digit-2 SHOW slot; DP=1 in all guard intervals.
- Mid-slot LOAD and reset:
  - LOAD 16'h0008 during the digit-0 SHOW slot -> SEG changes to 0000000 on the next edge while AN stays 1110.
  - Assert RST mid-slot -> AN=1111, SEG=1111111 with no clock edge.
  - After release, the first lit digit is digit 0 after GUARD cycles, showing '0' because the shadow was cleared.
